// File: rtl/foc_pwm_modulator_if.sv
// Phase-voltage command bus between the FOC core (master) and the PWM
// modulator (slave). The strobe qualifies all three commands at once and the
// modulator answers with a one-cycle acknowledge when the commands go live.
interface foc_pwm_modulator_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] phase_voltage_0;
  logic signed [DATA_W-1:0] phase_voltage_1;
  logic signed [DATA_W-1:0] phase_voltage_2;
  logic                     voltage_valid;
  logic                     update_ack;

  modport master (
    output phase_voltage_0,
    output phase_voltage_1,
    output phase_voltage_2,
    output voltage_valid,
    input  update_ack
  );

  modport slave (
    input  phase_voltage_0,
    input  phase_voltage_1,
    input  phase_voltage_2,
    input  voltage_valid,
    output update_ack
  );
endinterface

// File: rtl/foc_pwm_modulator.sv
// Center-aligned three-phase PWM modulator with per-leg dead-time insertion.
// Voltage commands are scaled to compare values, staged in a pending bank and
// swapped into the active bank only at the triangle valley, so a period is
// never built from a mix of old and new compares. An ADC trigger is raised at
// the triangle peak, where every low-side switch conducts.
module foc_pwm_modulator #(
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 10,
  parameter int PERIOD   = 800,
  parameter int DEADTIME = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  foc_pwm_modulator_if.slave cmd,
  output logic [2:0]         pwm_h,
  output logic [2:0]         pwm_l,
  output logic               sample_trigger
);

  localparam int PROD_W = DATA_W + CNT_W;
  localparam int DT_W   = $clog2(DEADTIME + 1);

  localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(PERIOD / 2);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [DT_W-1:0]  DT_FULL   = DT_W'(DEADTIME);
  localparam logic [DT_W-1:0]  DT_RELOAD = DT_W'(DEADTIME - 1);
  localparam logic [DT_W-1:0]  DT_ZERO   = {DT_W{1'b0}};
  localparam logic [DT_W-1:0]  DT_ONE    = DT_W'(1);

  typedef enum logic [1:0] {
    LEG_LOW  = 2'd0,
    LEG_HIGH = 2'd1,
    LEG_DEAD = 2'd2
  } leg_state_e;

  // Offset-binary conversion (flip the sign bit) then a full-width multiply,
  // keeping only the integer part of the fraction of PERIOD.
  function automatic logic [CNT_W-1:0] scale_cmd(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] biased;
    logic [PROD_W-1:0] prod;
    biased = {~v[DATA_W-1], v[DATA_W-2:0]};
    prod   = PROD_W'(biased) * PROD_W'(PERIOD_C);
    return CNT_W'(prod >> DATA_W);
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_up_q, dir_up_d;
  logic             pend_flag_q, pend_flag_d;
  logic [CNT_W-1:0] pend_q [3];
  logic [CNT_W-1:0] pend_d [3];
  logic [CNT_W-1:0] act_q [3];
  logic [CNT_W-1:0] act_d [3];
  logic [CNT_W-1:0] cmp_s [3];
  logic             xfer_s;
  logic [2:0]       ref_s;

  leg_state_e       state_q [3];
  leg_state_e       state_d [3];
  logic [2:0]       tgt_q, tgt_d;
  logic [DT_W-1:0]  dt_q [3];
  logic [DT_W-1:0]  dt_d [3];
  logic [2:0]       pwm_h_q, pwm_h_d;
  logic [2:0]       pwm_l_q, pwm_l_d;

  // Triangle counter: 0..PERIOD up, PERIOD-1..1 down; parked at 0 when disabled.
  always_comb begin
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    if (!enable) begin
      cnt_d    = CNT_ZERO;
      dir_up_d = 1'b1;
    end else if (dir_up_q) begin
      if (cnt_q >= PERIOD_C) begin
        cnt_d    = PERIOD_C - CNT_ONE;
        dir_up_d = 1'b0;
      end else begin
        cnt_d    = cnt_q + CNT_ONE;
        dir_up_d = 1'b1;
      end
    end else begin
      if (cnt_q <= CNT_ONE) begin
        cnt_d    = CNT_ZERO;
        dir_up_d = 1'b1;
      end else begin
        cnt_d    = cnt_q - CNT_ONE;
        dir_up_d = 1'b0;
      end
    end
  end

  // Scale the three incoming commands into compare values.
  always_comb begin
    cmp_s[0] = scale_cmd(cmd.phase_voltage_0);
    cmp_s[1] = scale_cmd(cmd.phase_voltage_1);
    cmp_s[2] = scale_cmd(cmd.phase_voltage_2);
  end

  // Valley swap of the pending bank into the active bank; a strobe in the
  // same cycle refills the pending bank and stays queued for the next valley.
  always_comb begin
    xfer_s      = enable & (cnt_q == CNT_ZERO) & pend_flag_q;
    pend_flag_d = pend_flag_q;
    for (int n = 0; n < 3; n++) begin
      pend_d[n] = pend_q[n];
      act_d[n]  = act_q[n];
    end
    if (xfer_s) begin
      pend_flag_d = 1'b0;
      for (int n = 0; n < 3; n++) begin
        act_d[n] = pend_q[n];
      end
    end else begin
      pend_flag_d = pend_flag_q;
    end
    if (cmd.voltage_valid) begin
      pend_flag_d = 1'b1;
      for (int n = 0; n < 3; n++) begin
        pend_d[n] = cmp_s[n];
      end
    end else begin
      pend_flag_d = pend_flag_d;
    end
  end

  // Per-leg dead-time FSM: every switch-on waits DEADTIME quiet cycles after
  // the last reference change; gate outputs are decoded from the next state.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      ref_s[n]   = (cnt_q < act_q[n]);
      state_d[n] = state_q[n];
      tgt_d[n]   = tgt_q[n];
      dt_d[n]    = dt_q[n];
      if (!enable) begin
        state_d[n] = LEG_DEAD;
        tgt_d[n]   = 1'b0;
        dt_d[n]    = DT_RELOAD;
      end else begin
        case (state_q[n])
          LEG_LOW: begin
            if (ref_s[n]) begin
              state_d[n] = LEG_DEAD;
              tgt_d[n]   = 1'b1;
              dt_d[n]    = DT_RELOAD;
            end else begin
              state_d[n] = LEG_LOW;
            end
          end
          LEG_HIGH: begin
            if (!ref_s[n]) begin
              state_d[n] = LEG_DEAD;
              tgt_d[n]   = 1'b0;
              dt_d[n]    = DT_RELOAD;
            end else begin
              state_d[n] = LEG_HIGH;
            end
          end
          LEG_DEAD: begin
            if (ref_s[n] != tgt_q[n]) begin
              tgt_d[n] = ref_s[n];
              dt_d[n]  = DT_RELOAD;
            end else if (dt_q[n] == DT_ZERO) begin
              state_d[n] = tgt_q[n] ? LEG_HIGH : LEG_LOW;
            end else begin
              dt_d[n] = dt_q[n] - DT_ONE;
            end
          end
          default: begin
            state_d[n] = LEG_DEAD;
            tgt_d[n]   = 1'b0;
            dt_d[n]    = DT_RELOAD;
          end
        endcase
      end
      pwm_h_d[n] = (state_d[n] == LEG_HIGH);
      pwm_l_d[n] = (state_d[n] == LEG_LOW);
    end
  end

  // Counter and compare-bank registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= CNT_ZERO;
      dir_up_q    <= 1'b1;
      pend_flag_q <= 1'b0;
      for (int n = 0; n < 3; n++) begin
        pend_q[n] <= HALF_C;
        act_q[n]  <= HALF_C;
      end
    end else begin
      cnt_q       <= cnt_d;
      dir_up_q    <= dir_up_d;
      pend_flag_q <= pend_flag_d;
      for (int n = 0; n < 3; n++) begin
        pend_q[n] <= pend_d[n];
        act_q[n]  <= act_d[n];
      end
    end
  end

  // Leg FSM state and registered gate drives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_q   <= 3'b000;
      pwm_h_q <= 3'b000;
      pwm_l_q <= 3'b000;
      for (int n = 0; n < 3; n++) begin
        state_q[n] <= LEG_DEAD;
        dt_q[n]    <= DT_FULL;
      end
    end else begin
      tgt_q   <= tgt_d;
      pwm_h_q <= pwm_h_d;
      pwm_l_q <= pwm_l_d;
      for (int n = 0; n < 3; n++) begin
        state_q[n] <= state_d[n];
        dt_q[n]    <= dt_d[n];
      end
    end
  end

  // Pulses are qualified by enable so neither can appear while stopped.
  assign cmd.update_ack  = xfer_s;
  assign sample_trigger  = enable & (cnt_q == PERIOD_C);
  assign pwm_h           = pwm_h_q;
  assign pwm_l           = pwm_l_q;

endmodule
